// File: rtl/uart_apb_regs.sv
// APB register block for a UART core: control, status, sticky interrupts, FIFO thresholds and DMA requests.
// Optional macro UART_APB_REGS_TIMEOUT_EN adds a wait-state timeout on stalled DATA writes.
module uart_apb_regs #(
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_AW    = 4,
  parameter int WAIT_LIMIT = 16
) (
  input  logic                  PCLK,
  input  logic                  PRESETn,
  input  logic [4:0]            PADDR,
  input  logic                  PSELx,
  input  logic                  PENABLE,
  input  logic                  PWRITE,
  input  logic [DATA_WIDTH-1:0] PWDATA,
  output logic                  PREADY,
  output logic [DATA_WIDTH-1:0] PRDATA,
  output logic                  PSLVERR,
  output logic                  tx_wr_en,
  output logic [7:0]            tx_wdata,
  input  logic                  tx_full,
  input  logic [FIFO_AW:0]      tx_cnt,
  output logic                  rx_rd_en,
  input  logic [7:0]            rx_rdata,
  input  logic                  rx_empty,
  input  logic [FIFO_AW:0]      rx_cnt,
  input  logic                  tx_busy,
  input  logic                  tx_done,
  input  logic                  rx_busy,
  input  logic                  rx_done,
  input  logic                  rx_err,
  output logic                  en_sys,
  output logic                  tx_en,
  output logic [1:0]            clk_freq_index,
  output logic [2:0]            baud_rate_index,
  output logic                  irq,
  output logic                  dma_tx_req,
  output logic                  dma_rx_req
);

  localparam int CW = FIFO_AW + 1;
  localparam logic [CW-1:0] DEPTH = CW'(2**FIFO_AW);

  typedef enum logic [1:0] {IDLE, SETUP, WAIT} state_t;

  state_t          state_q, state_d;
  logic [7:0]      ctrl_q;
  logic [4:0]      int_en_q;
  logic [2:0]      sticky_q, sticky_d, w1c;
  logic [CW-1:0]   rx_th_q, tx_th_q;
  logic [31:0]     stat_q, stat_d;
  logic            tx_wr_en_q, irq_q, dma_tx_q, dma_rx_q;
  logic [7:0]      tx_wdata_q;
  logic [31:0]     wdata32, rdata32;
  logic [2:0]      reg_idx;
  logic            addr_ok, sel_data, sel_ctrl, sel_stat, sel_int, sel_inten, sel_thresh;
  logic            access, stall, timeout, complete, err, wr_ok, rd_ok;
  logic            rx_thr, tx_thr;
  logic [4:0]      int_stat;
  logic            unused_bits;

  function automatic logic [CW-1:0] sat_cnt(input logic [CW-1:0] v);
    return (v > DEPTH) ? DEPTH : v;
  endfunction

  assign wdata32    = 32'(PWDATA);
  assign reg_idx    = PADDR[4:2];
  assign addr_ok    = (PADDR[1:0] == 2'b00) && (reg_idx <= 3'd5);
  assign sel_data   = addr_ok && (reg_idx == 3'd0);
  assign sel_ctrl   = addr_ok && (reg_idx == 3'd1);
  assign sel_stat   = addr_ok && (reg_idx == 3'd2);
  assign sel_int    = addr_ok && (reg_idx == 3'd3);
  assign sel_inten  = addr_ok && (reg_idx == 3'd4);
  assign sel_thresh = addr_ok && (reg_idx == 3'd5);

  // Only a DATA write into a full TX FIFO can stall the access phase
  assign access = PSELx && PENABLE && (state_q != IDLE);
  assign stall  = access && PWRITE && sel_data && tx_full;

`ifdef UART_APB_REGS_TIMEOUT_EN
  logic [7:0] wait_cnt_q;

  // Counts stalled access cycles; the access is forced to finish after WAIT_LIMIT of them
  assign timeout = stall && (state_q == WAIT) && (wait_cnt_q == 8'(WAIT_LIMIT));

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn)              wait_cnt_q <= '0;
    else if (stall && !timeout) wait_cnt_q <= wait_cnt_q + 8'd1;
    else                       wait_cnt_q <= '0;
  end

  assign unused_bits = ^{wdata32, rdata32};
`else
  assign timeout     = 1'b0;
  assign unused_bits = ^{wdata32, rdata32, 8'(WAIT_LIMIT)};
`endif

  assign PREADY   = !stall || timeout;
  assign complete = access && PREADY;
  assign err      = !addr_ok || (PWRITE && sel_stat) || (!PWRITE && sel_data && rx_empty) || timeout;
  assign PSLVERR  = complete && err;
  assign wr_ok    = complete && PWRITE && !err;
  assign rd_ok    = complete && !PWRITE && !err;
  assign rx_rd_en = rd_ok && sel_data;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:        if (PSELx && !PENABLE) state_d = SETUP;
      SETUP, WAIT: state_d = (!(PSELx && PENABLE) || PREADY) ? IDLE : WAIT;
      default:     state_d = IDLE;
    endcase
  end

  assign rx_thr   = (rx_th_q != '0) && (rx_cnt >= rx_th_q);
  assign tx_thr   = (tx_cnt <= tx_th_q);
  assign int_stat = {tx_thr, rx_thr, sticky_q};
  assign w1c      = (wr_ok && sel_int) ? wdata32[2:0] : 3'b000;
  // A set pulse arriving with a clear of the same bit keeps the bit set
  assign sticky_d = (sticky_q & ~w1c) | {rx_err, tx_done, rx_done};

  always_comb begin
    stat_d            = '0;
    stat_d[0]         = rx_empty;
    stat_d[2]         = rx_busy;
    stat_d[4]         = tx_full;
    stat_d[6]         = tx_busy;
    stat_d[8 +: CW]   = rx_cnt;
    stat_d[16 +: CW]  = tx_cnt;
  end

  always_comb begin
    rdata32 = '0;
    if (rd_ok) begin
      case (reg_idx)
        3'd0: rdata32[7:0] = rx_rdata;
        3'd1: rdata32[7:0] = ctrl_q;
        3'd2: rdata32      = stat_q;
        3'd3: rdata32[4:0] = int_stat;
        3'd4: rdata32[4:0] = int_en_q;
        3'd5: begin
          rdata32[CW-1:0]   = rx_th_q;
          rdata32[16 +: CW] = tx_th_q;
        end
        default: rdata32 = '0;
      endcase
    end
  end

  assign PRDATA = rdata32[DATA_WIDTH-1:0];

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q    <= IDLE;
      ctrl_q     <= '0;
      int_en_q   <= '0;
      sticky_q   <= '0;
      rx_th_q    <= '0;
      tx_th_q    <= '0;
      stat_q     <= '0;
      tx_wr_en_q <= 1'b0;
      tx_wdata_q <= '0;
      irq_q      <= 1'b0;
      dma_tx_q   <= 1'b0;
      dma_rx_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      sticky_q   <= sticky_d;
      stat_q     <= stat_d;
      tx_wr_en_q <= wr_ok && sel_data;
      if (wr_ok && sel_data)  tx_wdata_q <= wdata32[7:0];
      // Bit 1 of CTRL is reserved and always reads back as zero
      if (wr_ok && sel_ctrl)  ctrl_q     <= wdata32[7:0] & 8'hFD;
      if (wr_ok && sel_inten) int_en_q   <= wdata32[4:0];
      if (wr_ok && sel_thresh) begin
        rx_th_q <= sat_cnt(wdata32[CW-1:0]);
        tx_th_q <= sat_cnt(wdata32[16 +: CW]);
      end
      irq_q    <= |(int_stat & int_en_q);
      dma_tx_q <= ctrl_q[7] & tx_thr;
      dma_rx_q <= rx_thr;
    end
  end

  assign tx_wr_en        = tx_wr_en_q;
  assign tx_wdata        = tx_wdata_q;
  assign en_sys          = ctrl_q[0];
  assign clk_freq_index  = ctrl_q[3:2];
  assign baud_rate_index = ctrl_q[6:4];
  assign tx_en           = ctrl_q[7];
  assign irq             = irq_q;
  assign dma_tx_req      = dma_tx_q;
  assign dma_rx_req      = dma_rx_q;

endmodule

// File: doc/uart_apb_regs.md
UART_APB_REGS -- requirements
Module: uart_apb_regs

Interface
REQ-001 Parameter DATA_WIDTH, default 32: APB data bus width; SHALL be 16 or 32.
REQ-002 Parameter FIFO_AW, default 4: TX/RX FIFO address width; FIFO depth is 2**FIFO_AW.
REQ-003 Parameter WAIT_LIMIT, default 16: maximum wait-state cycles before timeout; range 1..255.
REQ-004 Clock and reset SHALL be: PCLK input 1, the single clock; PRESETn input 1, asynchronous active-low reset.
REQ-005 APB ports SHALL be: PADDR in 5; PSELx in 1; PENABLE in 1; PWRITE in 1; PWDATA in DATA_WIDTH; PREADY out 1; PRDATA out DATA_WIDTH; PSLVERR out 1.
REQ-006 TX FIFO ports SHALL be: tx_wr_en out 1; tx_wdata out 8; tx_full in 1; tx_cnt in FIFO_AW+1.
REQ-007 RX FIFO ports SHALL be: rx_rd_en out 1; rx_rdata in 8 (first-word-fall-through); rx_empty in 1; rx_cnt in FIFO_AW+1.
REQ-008 Core status inputs SHALL be: tx_busy, tx_done (pulse), rx_busy, rx_done (pulse), rx_err (pulse), each 1 bit.
REQ-009 Control outputs SHALL be: en_sys 1; tx_en 1; clk_freq_index 2; baud_rate_index 3; irq 1; dma_tx_req 1; dma_rx_req 1.

Function
REQ-010 Register map SHALL be: 0x00 DATA, 0x04 CTRL, 0x08 STAT (read-only), 0x0C INT_STAT (W1C), 0x10 INT_EN, 0x14 THRESH.
REQ-011 CTRL SHALL have fields en_sys [0], clk_freq_index [3:2], baud_rate_index [6:4] and tx_en [7]; the other bits SHALL read 0; the outputs SHALL be driven directly from these register bits.
REQ-012 STAT SHALL hold rx_empty [0], rx_busy [2], tx_full [4], tx_busy [6], rx_cnt [8 +: FIFO_AW+1] and tx_cnt [16 +: FIFO_AW+1], registered one cycle from the inputs.
REQ-013 The access FSM SHALL have states IDLE, SETUP and WAIT: IDLE->SETUP on PSELx & !PENABLE; SETUP->WAIT on a stalled access phase; otherwise SETUP->IDLE on completion; WAIT->IDLE on completion.
REQ-014 A write to DATA with tx_full=1 SHALL hold PREADY=0 (state WAIT) until tx_full=0; the access then completes with PREADY=1 and PSLVERR=0.
REQ-015 On a completed DATA write, tx_wr_en SHALL pulse for exactly one cycle, in the cycle after completion, with tx_wdata=PWDATA[7:0].
REQ-016 A DATA read with rx_empty=0 SHALL complete with no wait states, PRDATA={0,rx_rdata}, and rx_rd_en=1 combinationally during the completing cycle only.
REQ-017 A DATA read with rx_empty=1 SHALL complete immediately with PSLVERR=1, PRDATA=0 and rx_rd_en=0.
REQ-018 Unmapped addresses, PADDR[1:0]!=0, and writes to STAT SHALL complete with PREADY=1 and PSLVERR=1, with no state change and PRDATA=0.
REQ-019 INT_STAT SHALL hold sticky bits rx_done [0], tx_done [1] and rx_err [2], each set by its input pulse and cleared by writing 1.
REQ-020 If a set pulse and a W1C clear hit the same INT_STAT bit in the same cycle, set SHALL win.
REQ-021 INT_STAT SHALL hold level bits rx_thr [3] = (rx_th!=0 & rx_cnt>=rx_th) and tx_thr [4] = (tx_cnt<=tx_th); these are not writable.
REQ-022 irq SHALL be registered as |(INT_STAT & INT_EN[4:0]), giving one cycle of latency.
REQ-023 THRESH SHALL hold rx_th [FIFO_AW:0] and tx_th [16 +: FIFO_AW+1]; a written value above 2**FIFO_AW SHALL saturate to 2**FIFO_AW.
REQ-024 dma_tx_req SHALL be registered as tx_en & tx_thr; dma_rx_req SHALL be registered as rx_thr.
REQ-025 PRDATA SHALL be 0 whenever the cycle is not a completing read.

Reset
REQ-026 While PRESETn=0, all registers and all registered outputs SHALL be 0, the FSM SHALL be in IDLE, and PREADY SHALL be 1.
REQ-027 A reset asserted during WAIT SHALL abort the access; no tx_wr_en SHALL follow the reset.

Configuration
REQ-028 When macro UART_APB_REGS_TIMEOUT_EN is defined, a WAIT state lasting WAIT_LIMIT cycles SHALL complete the access with PREADY=1 and PSLVERR=1, and tx_wr_en SHALL not pulse.
REQ-029 When UART_APB_REGS_TIMEOUT_EN is not defined, WAIT SHALL persist indefinitely until tx_full=0, and no timeout counter SHALL exist.

Verification
REQ-030 Write CTRL=0x000000B5, then read it back -> PRDATA=0xB5; en_sys=1, clk_freq_index=1, baud_rate_index=3, tx_en=1.
REQ-031 Write DATA=0x5A with tx_full=1 held 5 cycles -> PREADY low for 5 cycles; after the access completes, tx_wr_en pulses once with tx_wdata=0x5A, PSLVERR=0.
REQ-032 With timeout enabled and WAIT_LIMIT=16, tx_full held at 1 -> completes after 16 wait cycles with PSLVERR=1 and no tx_wr_en.
REQ-033 Pulse rx_done in the same cycle as a write of INT_STAT=0x1, with INT_EN=0x1 -> INT_STAT[0] stays 1 and irq=1; a second write of 0x1 -> INT_STAT[0]=0 and irq=0 one cycle later.
REQ-034 Set THRESH rx_th=4 and sweep rx_cnt 3->4 -> dma_rx_req rises one cycle after rx_cnt=4; writing rx_th=31 with FIFO_AW=4 reads back as 16.
REQ-035 Read 0x18, then read DATA with rx_empty=1 -> PSLVERR=1 and PRDATA=0 for both; rx_rd_en stays 0.
